// File: rtl/mem_responder.sv
// Wait-stated memory responder for the multicycle processor's memory port.
// Accepts one request in IDLE, waits WAIT cycles, then performs the access and pulses mem_ready.
module mem_responder #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // WAIT is limited to 0..15, so the 4-bit counter never wraps.
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic [ADDR_W-1:0]   adr_reg, adr_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                wr_reg, wr_next;
  logic                ill_reg, ill_next;
  logic                mem_ready_reg, mem_ready_next;
  logic                err_reg, err_next;
  logic                mem_we, mem_re;
  logic [DATA_W-1:0]   read_data_reg;

  logic [DATA_W-1:0]   mem_array [2**ADDR_W];

  // State and control registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 4'd0;
      adr_reg       <= '0;
      data_reg      <= '0;
      wr_reg        <= 1'b0;
      ill_reg       <= 1'b0;
      mem_ready_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      adr_reg       <= adr_next;
      data_reg      <= data_next;
      wr_reg        <= wr_next;
      ill_reg       <= ill_next;
      mem_ready_reg <= mem_ready_next;
      err_reg       <= err_next;
    end
  end

  // Next-state logic; request inputs are only looked at in IDLE.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    adr_next   = adr_reg;
    data_next  = data_reg;
    wr_next    = wr_reg;
    ill_next   = ill_reg;
    case (state_reg)
      ST_IDLE: begin
        if (mem_read || mem_write) begin
          adr_next   = adr;
          data_next  = write_data;
          wr_next    = mem_write;
          ill_next   = mem_read & mem_write;
          cnt_next   = WAIT_CNT;
          state_next = (WAIT_CNT != 4'd0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg <= 4'd1) begin
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Access strobes and completion flags, registered on the ACCESS edge.
  always_comb begin
    mem_ready_next = 1'b0;
    err_next       = 1'b0;
    mem_we         = 1'b0;
    mem_re         = 1'b0;
    if (state_reg == ST_ACCESS) begin
      mem_ready_next = 1'b1;
      err_next       = ill_reg;
      mem_we         = wr_reg & ~ill_reg;
      mem_re         = ~wr_reg & ~ill_reg;
    end
  end

  // Storage has no reset, but a same-edge reset still suppresses the write.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_array[adr_reg] <= data_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_data_reg <= '0;
    end else if (mem_re) begin
      read_data_reg <= mem_array[adr_reg];
    end
  end

  assign read_data = read_data_reg;
  assign mem_ready = mem_ready_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with WAIT=2, one with WAIT=0,
// checked against an array model of memory contents and response timing.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]      rst_n_s;
  logic [1:0]      mem_read_s;
  logic [1:0]      mem_write_s;
  logic [1:0][4:0] adr_s;
  logic [1:0][7:0] wd_s;
  logic [1:0][7:0] rd_s;
  logic [1:0]      rdy_s;
  logic [1:0]      err_s;

  mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n_s[0]), .mem_read(mem_read_s[0]), .mem_write(mem_write_s[0]),
    .adr(adr_s[0]), .write_data(wd_s[0]), .read_data(rd_s[0]),
    .mem_ready(rdy_s[0]), .err(err_s[0])
  );

  mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT(0)) dut_w0 (
    .clk(clk), .rst_n(rst_n_s[1]), .mem_read(mem_read_s[1]), .mem_write(mem_write_s[1]),
    .adr(adr_s[1]), .write_data(wd_s[1]), .read_data(rd_s[1]),
    .mem_ready(rdy_s[1]), .err(err_s[1])
  );

  typedef struct {
    int       edge_no;
    bit       err;
    bit       known;
    bit [7:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  bit [7:0] model_mem [2][32];
  bit       model_valid [2][32];
  bit [7:0] exp_rd [2];
  bit       exp_rd_known [2];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int wait_of(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  function automatic void push_exp(input int u, input exp_t e);
    if (u == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  // Reference behaviour of one accepted request.
  function automatic void model_accept(input int u, input bit rd, input bit wr,
                                       input bit [4:0] a, input bit [7:0] d, input int k);
    exp_t e;
    e.edge_no = k + wait_of(u) + 1;
    e.err     = rd & wr;
    if (!e.err && wr) begin
      model_mem[u][a]   = d;
      model_valid[u][a] = 1'b1;
    end
    if (!e.err && rd) begin
      exp_rd[u]       = model_mem[u][a];
      exp_rd_known[u] = model_valid[u][a];
    end
    e.known = exp_rd_known[u];
    e.data  = exp_rd[u];
    push_exp(u, e);
  endfunction

  task automatic do_txn(input int u, input bit rd, input bit wr,
                        input bit [4:0] a, input bit [7:0] d);
    mem_read_s[u]  = rd;
    mem_write_s[u] = wr;
    adr_s[u]       = a;
    wd_s[u]        = d;
    @(posedge clk); #1;
    model_accept(u, rd, wr, a, d, cyc);
    mem_read_s[u]  = 1'b0;
    mem_write_s[u] = 1'b0;
    // Scramble the address/data inputs while the transaction is in flight.
    repeat (wait_of(u) + 1) begin
      adr_s[u] = 5'($urandom);
      wd_s[u]  = 8'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic check_eq(input string name, input int u, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s u=%0d edge=%0d: actual %0h required %0h", name, u, cyc, act, req);
    end
  endtask

  task automatic monitor_inst(input int u);
    exp_t e;
    bit   have;
    have = (u == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) e = (u == 0) ? q0[0] : q1[0];
    if (have && e.edge_no < cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_ready u=%0d: actual no mem_ready, required mem_ready after edge %0d", u, e.edge_no);
      if (u == 0) q0.delete(0);
      else        q1.delete(0);
    end else if (rdy_s[u] === 1'b1) begin
      if (!have) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ready u=%0d edge=%0d: actual mem_ready=1 required 0", u, cyc);
      end else begin
        if (u == 0) q0.delete(0);
        else        q1.delete(0);
        $display("resp u=%0d edge=%0d err=%0b read_data=%02h", u, cyc, err_s[u], rd_s[u]);
        check_eq("ready_edge", u, 8'(cyc), 8'(e.edge_no));
        check_eq("err", u, {7'd0, err_s[u]}, {7'd0, e.err});
        if (e.known) check_eq("read_data", u, rd_s[u], e.data);
      end
    end else if (err_s[u] !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL err_without_ready u=%0d edge=%0d: actual err=%b required 0", u, cyc, err_s[u]);
    end
  endtask

  always @(negedge clk) begin
    monitor_inst(0);
    monitor_inst(1);
  end

  task automatic random_phase(input int u, input int n);
    bit [4:0] a;
    int       r;
    for (int i = 0; i < n; i++) begin
      a = 5'($urandom);
      r = int'($urandom_range(0, 9));
      if (r == 0)                            do_txn(u, 1'b1, 1'b1, a, 8'($urandom));
      else if (r <= 4 || !model_valid[u][a]) do_txn(u, 1'b0, 1'b1, a, 8'($urandom));
      else                                   do_txn(u, 1'b1, 1'b0, a, 8'h00);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    rst_n_s     = 2'b00;
    mem_read_s  = 2'b11;
    mem_write_s = 2'b00;
    adr_s       = '0;
    wd_s        = '0;
    for (int u = 0; u < 2; u++) begin
      exp_rd[u]       = 8'h00;
      exp_rd_known[u] = 1'b1;
      for (int j = 0; j < 32; j++) model_valid[u][j] = 1'b0;
    end

    // Reset held two cycles with a read pending; outputs must stay quiet.
    repeat (2) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        check_eq("reset_ready", u, {7'd0, rdy_s[u]}, 8'd0);
        check_eq("reset_err", u, {7'd0, err_s[u]}, 8'd0);
        check_eq("reset_read_data", u, rd_s[u], 8'h00);
      end
    end
    rst_n_s = 2'b11;
    @(posedge clk); #1;
    for (int u = 0; u < 2; u++) model_accept(u, 1'b1, 1'b0, 5'd0, 8'h00, cyc);
    mem_read_s = 2'b00;
    repeat (4) begin
      @(posedge clk); #1;
    end

    // WAIT=2 directed cases.
    do_txn(0, 1'b0, 1'b1, 5'd5, 8'hA7);
    do_txn(0, 1'b1, 1'b0, 5'd5, 8'h00);
    do_txn(0, 1'b0, 1'b1, 5'd3, 8'h5C);
    do_txn(0, 1'b1, 1'b0, 5'd3, 8'h00);
    do_txn(0, 1'b0, 1'b1, 5'd7, 8'h3C);
    do_txn(0, 1'b1, 1'b0, 5'd5, 8'h00);
    do_txn(0, 1'b1, 1'b1, 5'd7, 8'hFF);
    do_txn(0, 1'b1, 1'b0, 5'd7, 8'h00);

    // Reset during WAIT drops the pending write and its response.
    do_txn(0, 1'b0, 1'b1, 5'd9, 8'h01);
    mem_write_s[0] = 1'b1;
    adr_s[0]       = 5'd9;
    wd_s[0]        = 8'h99;
    @(posedge clk); #1;
    mem_write_s[0] = 1'b0;
    rst_n_s[0]     = 1'b0;
    @(posedge clk); #1;
    rst_n_s[0]      = 1'b1;
    exp_rd[0]       = 8'h00;
    exp_rd_known[0] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("abort_ready", 0, {7'd0, rdy_s[0]}, 8'd0);
      check_eq("abort_read_data", 0, rd_s[0], 8'h00);
    end
    @(posedge clk); #1;
    do_txn(0, 1'b1, 1'b0, 5'd9, 8'h00);

    // WAIT=0 back-to-back, including the top address.
    do_txn(1, 1'b0, 1'b1, 5'd0, 8'h11);
    do_txn(1, 1'b0, 1'b1, 5'd31, 8'h22);
    do_txn(1, 1'b1, 1'b0, 5'd0, 8'h00);
    do_txn(1, 1'b1, 1'b0, 5'd31, 8'h00);
    do_txn(1, 1'b1, 1'b1, 5'd31, 8'h77);
    do_txn(1, 1'b1, 1'b0, 5'd31, 8'h00);

    random_phase(0, 40);
    random_phase(1, 40);

    repeat (6) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (q0.size() + q1.size() != 0) begin
      n_bad++;
      $display("FAIL drain: actual %0d responses outstanding, required 0", q0.size() + q1.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle processor's memory port. It accepts the processor's `MemRead`/`MemWrite` requests and performs the access against an internal word-addressed array after a programmable number of wait states. Completion is signalled with a one-cycle `mem_ready` pulse, which lets the controller stall in its memory states instead of assuming single-cycle memory. It sits beside the datapath and replaces the ideal memory.

## Interface
- `ADDR_W`, 5: address width; array depth is 2**ADDR_W words.
- `DATA_W`, 8: word width.
- `WAIT`, 2: wait states inserted between acceptance and access (0..15).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; one clock, synchronous, active-low.
- `mem_read`  in  1  read request level from the processor.
- `mem_write`  in  1  write request level from the processor.
- `adr`  in  ADDR_W  word address; sampled only at acceptance.
- `write_data`  in  DATA_W  store data; sampled only at acceptance.
- `read_data`  out  DATA_W  registered read result; holds its value until the next completed read.
- `mem_ready`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse coincident with `mem_ready` for an illegal request.

## Operation
- States:
  - IDLE: accepts requests.
  - WAIT: counts down the wait states.
  - ACCESS: performs the access and responds.
- IDLE transitions:
  - If `mem_read` or `mem_write` is 1, latch `adr`, `write_data`, the operation and the illegal flag (`mem_read & mem_write`).
  - Load the counter with `WAIT`.
  - Go to WAIT if `WAIT` > 0, else to ACCESS.
- WAIT: decrement the counter each cycle. Go to ACCESS on the cycle the counter reads 1. Input changes are ignored.
- ACCESS, normal write: store the latched data at the latched address. `read_data` is unchanged.
- ACCESS, normal read: `read_data` <= array[latched address].
- ACCESS, illegal request: no array write and no `read_data` update. `err` = 1.
- ACCESS outputs and exit: `mem_ready` = 1 for exactly this cycle, then go to IDLE.
- Requests are only sampled in IDLE. While in WAIT or ACCESS, requests do not queue.
- The requester holds its request until it sees `mem_ready`, and deasserts it in the next cycle. A request still high in the IDLE cycle after `mem_ready` is accepted as a new transaction, for example a repeated write.
- Array contents are not affected by reset. Contents are undefined until written.
- Counter width is 4 bits, and `WAIT` is limited to 15 so the counter cannot wrap.

## Timing
- Reset values: state IDLE, counter 0, `read_data` 0, `mem_ready` 0, `err` 0.
- A request is accepted at edge k.
  - `mem_ready`, `err` and the new `read_data` are registered at edge k+WAIT+1 and are visible in the cycle after it.
  - The earliest next acceptance is edge k+WAIT+2.
  - Per-transaction occupancy is therefore WAIT+2 cycles.
- With WAIT=0: accept at edge k, respond at edge k+1.
- A write becomes visible to a read accepted at or after the edge on which the write's `mem_ready` is registered.
- Reset mid-transaction, in WAIT or ACCESS: a low `rst_n` sampled on any edge forces the reset values.
  - A pending write is dropped unless its ACCESS edge has already passed.
  - No `mem_ready` is produced for the aborted transaction.
  - Reset has priority over a same-edge access.
- If `mem_read` and `mem_write` are both 1 at acceptance, the transaction follows the same latency with `err`=1 and `mem_ready`=1, and has no side effects.
- Addresses wrap naturally modulo 2**ADDR_W. No out-of-range case exists.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `mem_read`=1 → `mem_ready`=0, `err`=0, `read_data`=0 throughout. The first acceptance occurs on the first edge with `rst_n`=1.
- **Write then read (WAIT=2):**
  - Write `adr`=5 with `write_data`=0xA7, accepted at edge k → `mem_ready` is 1 exactly after edge k+3.
  - Then read `adr`=5 → `read_data`=0xA7 with `mem_ready` after 3 more edges.
- **Zero wait (WAIT=0):**
  - Back-to-back writes to addresses 0 and 31 (0x11, 0x22), then reads → each response 1 edge after acceptance; readback is 0x11 then 0x22.
  - Address 31 is read without aliasing.
- **Input stability:** change `adr` and `write_data` during WAIT after write acceptance at `adr`=3, data 0x5C → only address 3 is modified, and readback is 0x5C.
- **Illegal request:** after writing 0x3C to address 7, assert `mem_read`=`mem_write`=1 with `adr`=7, `write_data`=0xFF → `err`=`mem_ready`=1 for one cycle, `read_data` is unchanged, and a subsequent read of address 7 returns 0x3C.
- **Reset mid-write:** accept a write of 0x99 to address 9 (address 9 previously 0x01), then drop `rst_n` during WAIT → no `mem_ready`, and a read of address 9 after reset returns 0x01.
